ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 32 +++
 rtl/ps2_host_tx_if.sv | 19 +
 rtl/ps2_edge_filter.sv | 55 +++++
 rtl/ps2_host_tx.sv | 179 +++++++++++++++++
 tb/tb_ps2_host_tx.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, default timing constants,
// frame geometry and small helpers used by the host transmitter and keyboard receiver.
package ps2_pkg;

  localparam int unsigned DEF_INHIBIT_CYCLES = 6500;    // 100 us at 65 MHz
  localparam int unsigned DEF_START_CYCLES   = 64;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 975000;  // 15 ms at 65 MHz
  localparam int unsigned DEF_FILTER_LEN     = 8;

  // start + 8 data + parity + stop
  localparam int unsigned FRAME_BITS = 11;
  // Index of the stop bit among the bits the host drives after the start bit.
  localparam int unsigned STOP_IDX   = FRAME_BITS - 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_START     = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_tx_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the command issuer (master) and the PS/2 host
// transmitter (slave).
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_done, tx_error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_edge_filter.sv
// Two-flop synchronizers for the raw PS/2 lines plus a consecutive-sample filter
// on ps2_clk; o_clk_fall pulses for one cycle when the filtered clock goes 1->0.
module ps2_edge_filter
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
  input  logic pclk,
  input  logic rst,
  input  logic i_clk_raw,
  input  logic i_data_raw,
  output logic o_clk_sync,
  output logic o_data_sync,
  output logic o_clk_fall
);

  localparam int unsigned         FW     = cnt_width(FILTER_LEN);
  localparam logic [FW-1:0]       F_LAST = FW'(FILTER_LEN - 1);

  logic [1:0]    r_clk_ff;
  logic [1:0]    r_data_ff;
  logic          r_clk_filt;
  logic [FW-1:0] r_cnt;
  logic          r_fall;

  // Lines idle high, so every stage resets to 1 to avoid a phantom fall after reset.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_clk_ff   <= 2'b11;
      r_data_ff  <= 2'b11;
      r_clk_filt <= 1'b1;
      r_cnt      <= '0;
      r_fall     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let each flop sample the previous stage's old value, forming a real shift chain.
      r_clk_ff  <= {r_clk_ff[0], i_clk_raw};
      r_data_ff <= {r_data_ff[0], i_data_raw};
      r_fall    <= 1'b0;
      if (r_clk_ff[1] == r_clk_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == F_LAST) begin
        r_clk_filt <= r_clk_ff[1];
        r_cnt      <= '0;
        r_fall     <= ~r_clk_ff[1];
      end else begin
        r_cnt <= r_cnt + FW'(1);
      end
    end
  end

  assign o_clk_sync  = r_clk_ff[1];
  assign o_data_sync = r_data_ff[1];
  assign o_clk_fall  = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the clock, issues the start
// bit, shifts data/parity/stop on device clock falls, then collects the ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned START_CYCLES   = DEF_START_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned FILTER_LEN     = DEF_FILTER_LEN
) (
  input  logic          pclk,
  input  logic          rst,
  ps2_host_tx_if.slave  host,
  input  logic          ps2_clk_in,
  input  logic          ps2_data_in,
  output logic          ps2_clk_oe,
  output logic          ps2_data_oe,
  output logic          busy
);

  localparam int unsigned PH_CYCLES = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES
                                                                      : START_CYCLES;
  localparam int unsigned PH_W  = cnt_width(PH_CYCLES);
  localparam int unsigned TO_W  = cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned IDX_W = cnt_width(FRAME_BITS);

  localparam logic [PH_W-1:0]  INH_LAST   = PH_W'(INHIBIT_CYCLES - 1);
  localparam logic [PH_W-1:0]  START_LAST = PH_W'(START_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_LAST    = PH_W'(PH_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] STOP_POS   = IDX_W'(STOP_IDX);

  ps2_tx_state_e    r_state;
  ps2_tx_state_e    w_next_state;
  logic [PH_W-1:0]  r_phase_cnt;
  logic [TO_W-1:0]  r_to_cnt;
  logic [IDX_W-1:0] r_bit_idx;
  logic [9:0]       r_frame;      // {stop, parity, data}, sent from bit 0 upward
  logic             r_data_oe;
  logic             r_ack;

  logic w_clk_sync;
  logic w_data_sync;
  logic w_fall;
  logic w_accept;
  logic w_phase_done;
  logic w_to_active;
  logic w_timeout;

  ps2_edge_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_edge_filter (
    .pclk        (pclk),
    .rst         (rst),
    .i_clk_raw   (ps2_clk_in),
    .i_data_raw  (ps2_data_in),
    .o_clk_sync  (w_clk_sync),
    .o_data_sync (w_data_sync),
    .o_clk_fall  (w_fall)
  );

  assign w_accept     = (r_state == ST_IDLE) && host.tx_valid;
  assign w_phase_done = ((r_state == ST_INHIBIT) && (r_phase_cnt == INH_LAST)) ||
                        ((r_state == ST_START)   && (r_phase_cnt == START_LAST));
  assign w_to_active  = r_state inside {ST_SEND, ST_ACK, ST_WAIT_IDLE};
  // A fall restarts the timeout window, so it wins over an expiry in the same cycle.
  assign w_timeout    = w_to_active && !w_fall && (r_to_cnt == TO_LAST);

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    w_next_state  = r_state;
    host.tx_ready = 1'b0;
    host.tx_done  = 1'b0;
    host.tx_error = 1'b0;
    ps2_clk_oe    = 1'b0;
    ps2_data_oe   = 1'b0;
    busy          = 1'b1;
    case (r_state)
      ST_IDLE: begin
        host.tx_ready = 1'b1;
        busy          = 1'b0;
        if (host.tx_valid) w_next_state = ST_INHIBIT;
      end
      ST_INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (w_phase_done) w_next_state = ST_START;
      end
      ST_START: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
        if (w_phase_done) w_next_state = ST_SEND;
      end
      ST_SEND: begin
        ps2_data_oe = r_data_oe;
        if (w_fall && (r_bit_idx == STOP_POS)) begin
          w_next_state = ST_ACK;
        end else if (w_timeout) begin
          w_next_state  = ST_IDLE;
          host.tx_error = 1'b1;
        end
      end
      ST_ACK: begin
        if (w_fall) begin
          w_next_state = ST_WAIT_IDLE;
        end else if (w_timeout) begin
          w_next_state  = ST_IDLE;
          host.tx_error = 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        if (w_clk_sync && w_data_sync) begin
          w_next_state  = ST_IDLE;
          host.tx_done  = r_ack;
          host.tx_error = ~r_ack;
        end else if (w_timeout) begin
          w_next_state  = ST_IDLE;
          host.tx_error = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      r_phase_cnt <= '0;
      r_to_cnt    <= '0;
      r_bit_idx   <= '0;
      r_frame     <= '0;
      r_data_oe   <= 1'b0;
      r_ack       <= 1'b0;
    end else begin
      if ((r_state inside {ST_INHIBIT, ST_START}) && !w_phase_done) begin
        if (r_phase_cnt != PH_LAST) r_phase_cnt <= r_phase_cnt + PH_W'(1);
      end else begin
        r_phase_cnt <= '0;
      end

      // Held at zero outside the active window, so SEND is always entered with a fresh count.
      if (!w_to_active || w_fall) begin
        r_to_cnt <= '0;
      end else if (r_to_cnt != TO_LAST) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end

      if (w_accept) r_frame <= {1'b1, odd_parity(host.tx_data), host.tx_data};

      case (r_state)
        ST_START: begin
          if (w_phase_done) begin
            r_bit_idx <= '0;
            r_data_oe <= 1'b1;
          end
        end
        ST_SEND: begin
          if (w_fall) begin
            r_data_oe <= ~r_frame[r_bit_idx];
            if (r_bit_idx != STOP_POS) r_bit_idx <= r_bit_idx + IDX_W'(1);
          end
        end
        ST_ACK: begin
          if (w_fall) r_ack <= ~w_data_sync;
        end
        default: ;
      endcase

      if (w_next_state == ST_IDLE) r_data_oe <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: an open-drain PS/2 device model clocks frames
// out of the host, and a frame-level reference model predicts bits and outcomes.
module tb_ps2_host_tx;

  localparam int unsigned INH  = 65;
  localparam int unsigned STC  = 8;
  localparam int unsigned TO   = 2000;
  localparam int unsigned FL   = 8;
  localparam int unsigned LOW  = 30;   // device clock low half-period, in pclk cycles
  localparam int unsigned HIGH = 30;
  // A raw clock fall reaches the host FSM after 2 sync stages + FL filter samples;
  // the error strobe shows on the TO-th cycle counted from there.
  localparam int unsigned TO_LATENCY = FL + 2 + TO;

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe, busy;
  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_done = 0;
  int n_err  = 0;
  int n_both = 0;
  int n_acc  = 0;

  ps2_host_tx_if u_if ();

  // Open-drain wiring: either side can pull a line low.
  assign ps2_clk_in  = dev_clk  & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .START_CYCLES   (STC),
    .TIMEOUT_CYCLES (TO),
    .FILTER_LEN     (FL)
  ) u_dut (
    .pclk        (pclk),
    .rst         (rst),
    .host        (u_if),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy)
  );

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    n_done <= n_done + int'(u_if.tx_done);
    n_err  <= n_err  + int'(u_if.tx_error);
    n_both <= n_both + int'(u_if.tx_done & u_if.tx_error);
    n_acc  <= n_acc  + int'(u_if.tx_valid & u_if.tx_ready);
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, observed no end, required end");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Reference frame: data LSB first, odd parity by counting ones, stop bit 1.
  function automatic logic [9:0] model_bits(input logic [7:0] d);
    logic [9:0] b;
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      b[i] = d[i];
      ones += int'(d[i]);
    end
    b[8] = ((ones % 2) == 0);
    b[9] = 1'b1;
    return b;
  endfunction

  task automatic send_req(input logic [7:0] d, input bit hold);
    u_if.tx_data  = d;
    u_if.tx_valid = 1'b1;
    tick();
    if (!hold) u_if.tx_valid = 1'b0;
  endtask

  task automatic run_phase(output int inh, output int stc);
    int g;
    inh = 0;
    stc = 0;
    g   = 0;
    while (ps2_clk_oe && g < int'(INH + STC + 50)) begin
      if (ps2_data_oe) stc++;
      else inh++;
      tick();
      g++;
    end
    check("inhibit_len", inh, INH);
    check("start_len", stc, STC);
    check("start_bit_held", ps2_data_oe, 1'b1);
    repeat (20) tick();
  endtask

  task automatic dev_clock(input bit glitch, output bit s);
    dev_clk = 1'b0;
    repeat (LOW - 1) tick();
    s = ps2_data_in;
    tick();
    dev_clk = 1'b1;
    if (glitch) begin
      repeat (10) tick();
      dev_clk = 1'b0;
      tick();
      dev_clk = 1'b1;
      repeat (HIGH - 11) tick();
    end else begin
      repeat (HIGH) tick();
    end
  endtask

  task automatic frame(input logic [7:0] d, input bit ack, input bit glitch, input bit hold);
    logic [9:0] got;
    int inh, stc, g, d0, e0, a0;
    bit s;
    d0 = n_done;
    e0 = n_err;
    a0 = n_acc;
    send_req(d, hold);
    run_phase(inh, stc);
    for (int i = 0; i < 10; i++) begin
      dev_clock(glitch, s);
      got[i] = s;
    end
    check("frame_bits", got, model_bits(d));
    if (ack) dev_data = 1'b0;
    dev_clk = 1'b0;
    repeat (LOW) tick();
    dev_clk = 1'b1;
    repeat (4) tick();
    dev_data = 1'b1;
    g = 0;
    while (n_done == d0 && n_err == e0 && g < 200) begin
      tick();
      g++;
    end
    check("done_pulses", n_done - d0, ack ? 1 : 0);
    check("error_pulses", n_err - e0, ack ? 0 : 1);
    if (hold) begin
      check("accepts_during_frame", n_acc - a0, 1);
      tick();
      u_if.tx_valid = 1'b0;
      check("accepts_after_ready", n_acc - a0, 2);
      check("busy_after_reaccept", busy, 1'b1);
    end else begin
      tick();
      check("ready_after_frame", u_if.tx_ready, 1'b1);
    end
  endtask

  logic [7:0] rd;
  bit         rack;
  bit         s0;
  int         n, e0, d0, g;

  initial begin
    u_if.tx_data  = 8'h00;
    u_if.tx_valid = 1'b0;

    // Reset state
    #1 rst = 1'b0;
    #2;
    check("rst_clk_oe", ps2_clk_oe, 1'b0);
    check("rst_data_oe", ps2_data_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", u_if.tx_ready, 1'b1);
    check("rst_done_err", {u_if.tx_done, u_if.tx_error}, 2'b00);
    repeat (3) tick();
    rst = 1'b1;
    repeat (5) tick();

    // 0xED with ACK, then 0x07 with NACK
    frame(8'hED, 1'b1, 1'b0, 1'b0);
    frame(8'h07, 1'b0, 1'b0, 1'b0);

    // Glitches on the device clock during SEND must not advance the bit index
    frame(8'h00, 1'b1, 1'b1, 1'b0);

    // Randomized bytes and device responses
    for (int k = 0; k < 4; k++) begin
      rd   = 8'($urandom);
      rack = 1'($urandom_range(0, 1));
      frame(rd, rack, 1'b0, 1'b0);
    end

    // Device stops clocking after bit 3
    rd = 8'($urandom);
    e0 = n_err;
    d0 = n_done;
    send_req(rd, 1'b0);
    run_phase(n, g);
    for (int i = 0; i < 3; i++) dev_clock(1'b0, s0);
    dev_clk = 1'b0;
    n = 0;
    while (!u_if.tx_error && n < int'(TO_LATENCY + 100)) begin
      tick();
      n++;
      if (n == int'(LOW)) dev_clk = 1'b1;
    end
    check("timeout_latency", n, TO_LATENCY);
    tick();
    check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("timeout_ready", u_if.tx_ready, 1'b1);
    check("timeout_err_pulse", n_err - e0, 1);
    check("timeout_no_done", n_done - d0, 0);

    // Reset in the middle of bit 5
    e0 = n_err;
    d0 = n_done;
    send_req(8'h3C, 1'b0);
    run_phase(n, g);
    for (int i = 0; i < 5; i++) dev_clock(1'b0, s0);
    dev_clk = 1'b0;
    repeat (20) tick();
    #2 rst = 1'b0;
    #1;
    check("midrst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", u_if.tx_ready, 1'b1);
    dev_clk = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    repeat (20) tick();
    check("midrst_no_pulses", (n_err - e0) + (n_done - d0), 0);

    // 0xF4 with tx_valid held high: one frame per accept
    frame(8'hF4, 1'b1, 1'b0, 1'b1);
    e0 = n_err;
    g  = 0;
    while (!u_if.tx_error && g < int'(INH + STC + TO + 100)) begin
      tick();
      g++;
    end
    check("reaccept_frame_timeout", u_if.tx_error, 1'b1);
    tick();
    check("reaccept_err_pulse", n_err - e0, 1);

    check("no_done_error_overlap", n_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
